// File: rtl/timing_seq_pkg.sv
// Shared definitions for the timing sequencer: state encoding, defaults, clamp helper.
package timing_seq_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN,
    DONE = ST_DONE
  } state_e;

  localparam int DEF_NUM_STEPS = 8;
  localparam int DEF_CNT_W     = 8;

  // Limit a requested final step index to the last step that physically exists.
  function automatic int unsigned clamp_step(input int unsigned idx, input int unsigned n);
    return (idx > n - 1) ? n - 1 : idx;
  endfunction

endpackage

// File: rtl/onehot_decoder.sv
// One-hot decode of an index; all zero when disabled.
module onehot_decoder #(
  parameter int N  = 8,
  parameter int IW = $clog2(N)
) (
  input  logic [IW-1:0] idx_i,
  input  logic          en_i,
  output logic [N-1:0]  oh_o
);

  // One compare per output bit.
  for (genvar i = 0; i < N; i++) begin : g_bit
    assign oh_o[i] = en_i && (idx_i == IW'(i));
  end

endmodule

// File: rtl/timing_sequencer.sv
// Programmable one-hot timing generator with start/abort, clear, stall,
// single-pass or continuous mode and a saturating completed-pass counter.
module timing_sequencer
  import timing_seq_pkg::*;
#(
  parameter  int NUM_STEPS = DEF_NUM_STEPS,
  parameter  int CNT_W     = DEF_CNT_W,
  localparam int QW        = $clog2(NUM_STEPS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [QW-1:0]        last_step,
  input  logic                 wrap,
  input  logic                 clr,
  input  logic                 hold,
  input  logic                 abort,
  output logic [QW-1:0]        Q,
  output logic [NUM_STEPS-1:0] T,
  output logic                 step_last,
  output logic                 done,
  output logic                 busy,
  output logic [CNT_W-1:0]     pass_cnt
);

  localparam logic [QW-1:0] LAST_MAX = QW'(NUM_STEPS - 1);

  state_e           state_q, state_d;
  logic [QW-1:0]    q_q, q_d;
  logic [QW-1:0]    last_q, last_d;
  logic             wrap_q, wrap_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [QW-1:0]    last_clamped;

  assign last_clamped = QW'(clamp_step(32'(last_step), NUM_STEPS));

  // Next-state: FSM, step index, latched config and pass counter.
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    last_d  = last_q;
    wrap_d  = wrap_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          q_d     = '0;
          cnt_d   = '0;
          last_d  = last_clamped;
          wrap_d  = wrap;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
          q_d     = '0;
        end else if (clr) begin
          q_d = '0;
        end else if (!hold) begin
          if (q_q == last_q) begin
            // Pass completes as Q leaves the last step.
            if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
            q_d = '0;
            if (!wrap_q) state_d = DONE;
          end else begin
            q_d = q_q + 1'b1;
          end
        end
      end
      DONE: begin
        // Abort has the same effect as the normal DONE->IDLE exit.
        if (start && !abort) begin
          state_d = RUN;
          q_d     = '0;
          cnt_d   = '0;
          last_d  = last_clamped;
          wrap_d  = wrap;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        q_d     = '0;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      q_q     <= '0;
      last_q  <= LAST_MAX;
      wrap_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      last_q  <= last_d;
      wrap_q  <= wrap_d;
      cnt_q   <= cnt_d;
    end
  end

  assign Q         = q_q;
  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign step_last = busy && (q_q == last_q);
  assign pass_cnt  = cnt_q;

  onehot_decoder #(.N(NUM_STEPS), .IW(QW)) u_dec (
    .idx_i (q_q),
    .en_i  (busy),
    .oh_o  (T)
  );

endmodule

// File: tb/tb_timing_sequencer.sv
// Directed bench for timing_sequencer: default build, a 4-bit counter build
// for saturation and a 6-step build for clamping, all sharing one stimulus.
module tb_timing_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0, wrap = 1'b0, clr = 1'b0, hold = 1'b0, abort = 1'b0;
  logic [2:0] last_step = 3'd0;

  logic [2:0] Q,  Q4,  Q6;
  logic [7:0] T,  T4;
  logic [5:0] T6;
  logic       sl, sl4, sl6, dn, dn4, dn6, bz, bz4, bz6;
  logic [7:0] pc, pc6;
  logic [3:0] pc4;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  timing_sequencer #(.NUM_STEPS(8), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .last_step(last_step), .wrap(wrap),
    .clr(clr), .hold(hold), .abort(abort), .Q(Q), .T(T), .step_last(sl),
    .done(dn), .busy(bz), .pass_cnt(pc));

  timing_sequencer #(.NUM_STEPS(8), .CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .start(start), .last_step(last_step), .wrap(wrap),
    .clr(clr), .hold(hold), .abort(abort), .Q(Q4), .T(T4), .step_last(sl4),
    .done(dn4), .busy(bz4), .pass_cnt(pc4));

  timing_sequencer #(.NUM_STEPS(6), .CNT_W(8)) dut6 (
    .clk(clk), .reset(reset), .start(start), .last_step(last_step), .wrap(wrap),
    .clr(clr), .hold(hold), .abort(abort), .Q(Q6), .T(T6), .step_last(sl6),
    .done(dn6), .busy(bz6), .pass_cnt(pc6));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 0; clr = 0; hold = 0; abort = 0; wrap = 0; last_step = 3'd0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++; if (Q !== 3'd0)  begin n_err++; $display("FAIL reset_Q got %0d exp 0", Q); end
    n_vec++; if (T !== 8'h00) begin n_err++; $display("FAIL reset_T got %h exp 00", T); end
    n_vec++; if ({sl, dn, bz} !== 3'b000) begin n_err++; $display("FAIL reset_flags got %b exp 000", {sl, dn, bz}); end
    n_vec++; if (pc !== 8'd0) begin n_err++; $display("FAIL reset_pass_cnt got %0d exp 0", pc); end
  endtask

  task automatic test_single_pass();
    do_reset();
    last_step = 3'd7; wrap = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      n_vec++; if (T !== 8'(1 << i) || bz !== 1'b1) begin n_err++; $display("FAIL single_T step %0d got T=%h busy=%b exp T=%h busy=1", i, T, bz, 8'(1 << i)); end
      n_vec++; if (sl !== (i == 7)) begin n_err++; $display("FAIL single_step_last step %0d got %b exp %b", i, sl, (i == 7)); end
      tick();
    end
    n_vec++; if ({dn, bz} !== 2'b10 || T !== 8'h00 || pc !== 8'd1) begin n_err++; $display("FAIL single_done got done=%b busy=%b T=%h cnt=%0d exp 1 0 00 1", dn, bz, T, pc); end
    tick();
    n_vec++; if ({dn, bz} !== 2'b00 || T !== 8'h00 || pc !== 8'd1) begin n_err++; $display("FAIL single_idle got done=%b busy=%b T=%h cnt=%0d exp 0 0 00 1", dn, bz, T, pc); end
  endtask

  task automatic test_wrap_hold();
    logic [7:0] exp_t [9] = '{8'h01, 8'h02, 8'h02, 8'h02, 8'h04, 8'h01, 8'h02, 8'h04, 8'h01};
    logic [7:0] exp_c [9] = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd1, 8'd1, 8'd2};
    logic       hv    [9] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    do_reset();
    last_step = 3'd2; wrap = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 9; i++) begin
      n_vec++; if (T !== exp_t[i] || pc !== exp_c[i]) begin n_err++; $display("FAIL wrap_hold cyc %0d got T=%h cnt=%0d exp T=%h cnt=%0d", i, T, pc, exp_t[i], exp_c[i]); end
      hold = hv[i];
      tick();
    end
    hold = 1'b0;
  endtask

  task automatic test_clr_abort();
    do_reset();
    last_step = 3'd5; wrap = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (11) tick();
    n_vec++; if (Q !== 3'd5 || sl !== 1'b1 || pc !== 8'd1) begin n_err++; $display("FAIL clr_pre got Q=%0d sl=%b cnt=%0d exp 5 1 1", Q, sl, pc); end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    n_vec++; if (Q !== 3'd0 || T !== 8'h01 || bz !== 1'b1 || pc !== 8'd1) begin n_err++; $display("FAIL clr_post got Q=%0d T=%h busy=%b cnt=%0d exp 0 01 1 1", Q, T, bz, pc); end
    tick();
    abort = 1'b1; clr = 1'b1; hold = 1'b1;
    tick();
    abort = 1'b0; clr = 1'b0; hold = 1'b0;
    n_vec++; if (bz !== 1'b0 || T !== 8'h00 || Q !== 3'd0 || pc !== 8'd1) begin n_err++; $display("FAIL abort got busy=%b T=%h Q=%0d cnt=%0d exp 0 00 0 1", bz, T, Q, pc); end
  endtask

  task automatic test_boundaries();
    do_reset();
    last_step = 3'd0; wrap = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      n_vec++; if (T !== 8'h01 || sl !== 1'b1 || pc !== 8'(i)) begin n_err++; $display("FAIL l0_wrap cyc %0d got T=%h sl=%b cnt=%0d exp 01 1 %0d", i, T, sl, pc, i); end
      n_vec++; if (pc4 !== 4'((i > 15) ? 15 : i)) begin n_err++; $display("FAIL sat4 cyc %0d got %0d exp %0d", i, pc4, (i > 15) ? 15 : i); end
      tick();
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  task automatic test_mid_run();
    do_reset();
    last_step = 3'd7; wrap = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (2) tick();
    start = 1'b1; last_step = 3'd3;
    tick();
    start = 1'b0;
    n_vec++; if (Q !== 3'd3 || bz !== 1'b1 || sl !== 1'b0) begin n_err++; $display("FAIL start_in_run got Q=%0d busy=%b sl=%b exp 3 1 0", Q, bz, sl); end
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_vec++; if (Q !== 3'd0 || T !== 8'h00 || {sl, dn, bz} !== 3'b000 || pc !== 8'd0) begin n_err++; $display("FAIL mid_reset got Q=%0d T=%h flags=%b cnt=%0d exp 0 00 000 0", Q, T, {sl, dn, bz}, pc); end
    last_step = 3'd1; wrap = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (2) tick();
    n_vec++; if (dn !== 1'b1) begin n_err++; $display("FAIL done_pulse got %b exp 1", dn); end
    start = 1'b1; last_step = 3'd2;
    tick();
    start = 1'b0;
    n_vec++; if (bz !== 1'b1 || dn !== 1'b0 || Q !== 3'd0 || T !== 8'h01) begin n_err++; $display("FAIL start_in_done got busy=%b done=%b Q=%0d T=%h exp 1 0 0 01", bz, dn, Q, T); end
    repeat (2) tick();
    n_vec++; if (Q !== 3'd2 || sl !== 1'b1) begin n_err++; $display("FAIL relatch got Q=%0d sl=%b exp 2 1", Q, sl); end
  endtask

  task automatic test_clamp();
    do_reset();
    last_step = 3'd7; wrap = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      n_vec++; if (T6 !== 6'(1 << i) || bz6 !== 1'b1 || sl6 !== (i == 5)) begin n_err++; $display("FAIL clamp step %0d got T=%h busy=%b sl=%b exp T=%h 1 %b", i, T6, bz6, sl6, 6'(1 << i), (i == 5)); end
      tick();
    end
    n_vec++; if (dn6 !== 1'b1 || T6 !== 6'h00 || pc6 !== 8'd1) begin n_err++; $display("FAIL clamp_done got done=%b T=%h cnt=%0d exp 1 00 1", dn6, T6, pc6); end
  endtask

  initial begin
    test_reset();
    test_single_pass();
    test_wrap_hold();
    test_clr_abort();
    test_boundaries();
    test_mid_run();
    test_clamp();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
